// File: rtl/popcount_requester_if.sv
// Handshake bundle between a word source, the popcount requester, its responder
// and the downstream count sink. master = requester side, slave = environment side.
interface popcount_requester_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         start;
  logic [N-1:0] A;
  logic         done;
  logic [N-1:0] result;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         busy;
  logic         timeout_err;

  modport master (
    input  in_valid, in_data, done, result, out_ready,
    output in_ready, start, A, out_valid, out_data, busy, timeout_err
  );

  modport slave (
    output in_valid, in_data, done, result, out_ready,
    input  in_ready, start, A, out_valid, out_data, busy, timeout_err
  );
endinterface

// File: rtl/popcount_requester.sv
// Initiator of the start/done popcount handshake; one request outstanding at a time.
// Define TIMEOUT_EN to add a watchdog on the REQ and DRAIN waits.
module popcount_requester #(
  parameter int N              = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  popcount_requester_if.master bus
);

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    REQ   = 4'b0010,
    DRAIN = 4'b0100,
    OUT   = 4'b1000
  } state_t;

  state_t       state, nxt;
  logic         accept, capture, tmo_req, tmo_drain, timeout_hit;
  logic         start_q;
  logic [N-1:0] a_q;
  logic [N-1:0] out_data_q;

  if (TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // done has priority over the watchdog so a late-but-valid result is never lost
  always_comb begin
    nxt       = state;
    accept    = 1'b0;
    capture   = 1'b0;
    tmo_req   = 1'b0;
    tmo_drain = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          accept = 1'b1;
          nxt    = REQ;
        end
      end
      REQ: begin
        if (bus.done) begin
          capture = 1'b1;
          nxt     = DRAIN;
        end else if (timeout_hit) begin
          tmo_req = 1'b1;
          nxt     = DRAIN;
        end
      end
      DRAIN: begin
        if (!bus.done) begin
          nxt = OUT;
        end else if (timeout_hit) begin
          tmo_drain = 1'b1;
          nxt       = OUT;
        end
      end
      OUT: begin
        if (bus.out_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q    <= 1'b0;
      a_q        <= '0;
      out_data_q <= '0;
    end else begin
      if (accept) begin
        a_q     <= bus.in_data;
        start_q <= 1'b1;
      end
      if (capture) begin
        out_data_q <= bus.result;
        start_q    <= 1'b0;
      end
      if (tmo_req) begin
        out_data_q <= '1;
        start_q    <= 1'b0;
      end
    end
  end

`ifdef TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wd_cnt;
  logic          err_q;

  // counter restarts on every state change, so it times REQ and DRAIN separately
  assign timeout_hit = (wd_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state != nxt)
        wd_cnt <= '0;
      else if (state == REQ || state == DRAIN)
        wd_cnt <= wd_cnt + CW'(1);
      if (accept)
        err_q <= 1'b0;
      else if (tmo_req || tmo_drain)
        err_q <= 1'b1;
    end
  end

  assign bus.timeout_err = err_q;
`else
  assign timeout_hit     = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = (state == OUT);
  assign bus.start     = start_q;
  assign bus.A         = a_q;
  assign bus.out_data  = out_data_q;

endmodule

// File: doc/popcount_requester.md
Name: popcount_requester

Overview:
Initiator side of the start/done popcount handshake. Accepts N-bit words from an upstream valid/ready stream and presents each word on A. Drives start, waits for done, captures result, then runs the return-to-idle half of the handshake. Delivers the count on a downstream valid/ready stream. Sits between a word source and one popcount responder instance, and serialises requests to it.

Parameters:
N, 8, word width; also the width of result and out_data.
TIMEOUT_CYCLES, 64, watchdog limit in cycles; used only when TIMEOUT_EN is defined.

Ports:
clk  input  1  clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  upstream word valid.
in_ready  output  1  upstream ready; high only in IDLE.
in_data  input  N  upstream word.
start  output  1  request to responder; registered, level.
A  output  N  word to responder; registered.
done  input  1  responder completion; level, same clock domain.
result  input  N  responder count; valid while done=1.
out_valid  output  1  downstream count valid.
out_ready  input  1  downstream ready.
out_data  output  N  captured count.
busy  output  1  high in any state other than IDLE.
timeout_err  output  1  sticky watchdog flag; constant 0 without TIMEOUT_EN.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: state=IDLE, start=0, A=0, out_valid=0, out_data=0, timeout_err=0. in_ready=1 while in IDLE out of reset; busy=0.
- Reset asserted mid-operation: immediate return to IDLE with all registers at reset values. The responder is expected to be reset by the same rst_n.
- State machine: one-hot, states IDLE, REQ, DRAIN, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid=1: latch in_data into A and go to REQ.
  - start rises on the same edge. A and start are both registered, so the first start=1 cycle is the cycle after acceptance.
- REQ:
  - start=1; A held stable.
  - Sample done each cycle. On done=1: capture result into out_data and go to DRAIN. start falls on that same edge.
- DRAIN:
  - start=0; wait for done=0, which means the responder is back in its idle state.
  - On done=0 go to OUT.
  - A stays unchanged until the next acceptance.
- OUT:
  - out_valid=1; out_data stable.
  - On out_ready=1 (the transfer edge) go to IDLE, and out_valid drops on that edge.
  - Next word can be accepted on the following cycle at the earliest. There is no IDLE-to-IDLE bypass.
- done=1 while in IDLE or OUT: ignored, with no state change.
- in_valid while not in IDLE: ignored; upstream must hold the word.
- out_ready while out_valid=0: ignored.
- Width: out_data is N bits and carries result unmodified. The valid counts are 0..N.
- Exactly one request is outstanding at a time. start is never reasserted until done has been observed low in DRAIN.

Optional Feature:
TIMEOUT_EN
- Defined: a cycle counter is cleared on entry to REQ and on entry to DRAIN, and increments in those states.
  - If it reaches TIMEOUT_CYCLES in REQ: out_data <= all ones (8'hFF for N=8, which is distinguishable from any valid count), timeout_err <= 1, go to DRAIN.
  - If it reaches TIMEOUT_CYCLES in DRAIN: go to OUT. Keep out_data as already captured, or as the sentinel if the REQ stage also timed out. Set timeout_err <= 1.
  - timeout_err is cleared only on the next IDLE acceptance or on reset.
- Undefined: no counter, REQ and DRAIN wait indefinitely, and timeout_err is tied 0.

Test Plan:
- Connect the requester to a popcount responder, N=8. Send in_data=8'hA5 with out_ready=1. Required: out_data=4 with out_valid=1 for one cycle; start observed high and then low exactly once.
- Send in_data=8'h00, then 8'hFF, back-to-back with in_valid held. Required: outputs 0 then 8, in order; in_ready low between acceptances; A never changes while start=1.
- Send in_data=8'h81 with out_ready=0 for 10 cycles after out_valid rises. Required: out_valid stays 1, out_data stays 2, in_ready stays 0, busy=1. Transfer completes on the cycle out_ready rises.
- Pulse rst_n low during REQ (start=1). Required: start=0, out_valid=0 and in_ready=1 immediately. A following word 8'h0F yields 4.
- Force done=1 while in IDLE. Required: no state change and no out_valid. Then force a responder that never raises done, with TIMEOUT_EN defined and TIMEOUT_CYCLES=64. Required: after 64 REQ cycles out_data=8'hFF and timeout_err=1; timeout_err clears on the next acceptance.
- Without TIMEOUT_EN, stall done low for 200 cycles. Required: the requester remains in REQ with start=1 and timeout_err=0.
